// File: rtl/keymgr_kmac_rsp.sv
// kmac-side responder for the keymgr application interface: folds data beats into a digest
// and returns a two-share masked result. Define KEYMGR_KMAC_RSP_STALL_EN for LFSR backpressure.
module keymgr_kmac_rsp #(
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned DigestWidth = 256,
   parameter int unsigned MaxBytes    = 128,
   parameter int unsigned ProcLatency = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   input  logic [DataWidth-1:0]     req_data_i,
   input  logic [DataWidth/8-1:0]   req_strb_i,
   input  logic                     req_last_i,
   output logic                     req_ready_o,
   input  logic [DigestWidth-1:0]   mask_i,
   output logic                     rsp_done_o,
   output logic [DigestWidth-1:0]   rsp_share0_o,
   output logic [DigestWidth-1:0]   rsp_share1_o,
   output logic                     rsp_error_o,
   output logic                     busy_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned Lanes     = DigestWidth / DataWidth;
   localparam int unsigned ByteCntW  = $clog2(MaxBytes + 1) + 1;
   localparam int unsigned LatW      = (ProcLatency > 1) ? $clog2(ProcLatency) : 1;
   localparam logic [ByteCntW:0] MaxBytesW = (ByteCntW + 1)'(MaxBytes);

   typedef enum logic [1:0] {
      StAbsorb  = 2'b00,
      StProcess = 2'b01,
      StDone    = 2'b10
   } state_e;

   state_e                 state_q, state_d;
   logic [DigestWidth-1:0] acc_q, mask_q;
   logic [ByteCntW-1:0]    byte_cnt_q;
   logic [7:0]             beat_idx_q;
   logic [LatW-1:0]        lat_cnt_q;
   logic                   err_q, in_msg_q;
   logic                   stall, accept;

   logic [DataWidth-1:0]   beat_m;
   logic [31:0]            lane;
   logic [DigestWidth-1:0] acc_fold;
   logic [ByteCntW:0]      cnt_sum;
   logic [ByteCntW-1:0]    cnt_sat;
   logic                   strb_err, beat_err;

   function automatic logic [ByteCntW:0] popcount(input logic [StrbWidth-1:0] s);
      popcount = '0;
      for (int i = 0; i < StrbWidth; i++) popcount = popcount + (ByteCntW + 1)'(s[i]);
   endfunction

`ifdef KEYMGR_KMAC_RSP_STALL_EN
   logic [3:0] lfsr_q;

   // x^4+x^3+1, only stepping while absorbing so the stall pattern is deterministic per message
   always_ff @(posedge clk_i) begin
      if (rst_i)                  lfsr_q <= 4'b1001;
      else if (state_q == StAbsorb) lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
   end
   assign stall = lfsr_q[0];
`else
   assign stall = 1'b0;
`endif

   assign accept = req_valid_i && req_ready_o;

   always_comb begin
      beat_m = '0;
      for (int i = 0; i < StrbWidth; i++) begin
         if (req_strb_i[i]) beat_m[8*i +: 8] = req_data_i[8*i +: 8];
      end
   end

   always_comb begin
      lane     = 32'(beat_idx_q) % Lanes;
      acc_fold = {acc_q[DigestWidth-2:0], acc_q[DigestWidth-1]}
                 ^ (DigestWidth'(beat_m) << (lane * DataWidth));
      cnt_sum  = {1'b0, byte_cnt_q} + popcount(req_strb_i);
      cnt_sat  = cnt_sum[ByteCntW] ? '1 : cnt_sum[ByteCntW-1:0];
      // A final beat must strobe a contiguous run starting at byte 0.
      strb_err = req_last_i ? ((req_strb_i == '0) ||
                               ((req_strb_i & (req_strb_i + StrbWidth'(1))) != '0))
                            : (req_strb_i != '1);
      beat_err = strb_err || (cnt_sum > MaxBytesW);
   end

   // NOTE: defaults are assigned first so every path drives state_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StAbsorb:  if (accept && req_last_i) state_d = StProcess;
         StProcess: if (lat_cnt_q == '0)      state_d = StDone;
         StDone:    state_d = StAbsorb;
         default:   state_d = StDone;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= StAbsorb;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q      <= '0;
         mask_q     <= '0;
         byte_cnt_q <= '0;
         beat_idx_q <= '0;
         lat_cnt_q  <= '0;
         err_q      <= 1'b0;
         in_msg_q   <= 1'b0;
      end else begin
         case (state_q)
            StAbsorb: begin
               if (accept) begin
                  acc_q      <= acc_fold;
                  byte_cnt_q <= cnt_sat;
                  beat_idx_q <= beat_idx_q + 8'd1;
                  err_q      <= err_q | beat_err;
                  in_msg_q   <= !req_last_i;
                  if (req_last_i) begin
                     mask_q    <= mask_i;
                     lat_cnt_q <= LatW'(ProcLatency - 1);
                  end
               end
            end
            StProcess: if (lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - LatW'(1);
            StDone: begin
               acc_q      <= '0;
               byte_cnt_q <= '0;
               beat_idx_q <= '0;
               err_q      <= 1'b0;
            end
            // Corrupted encoding: force a single erroring done that exposes no digest.
            default: err_q <= 1'b1;
         endcase
      end
   end

   assign req_ready_o  = !rst_i && (state_q == StAbsorb) && !stall;
   assign rsp_done_o   = !rst_i && (state_q == StDone);
   assign rsp_share1_o = rsp_done_o ? mask_q : '0;
   assign rsp_share0_o = rsp_done_o ? (err_q ? mask_q : (acc_q ^ mask_q)) : '0;
   assign rsp_error_o  = rsp_done_o && err_q;
   assign busy_o       = !rst_i && ((state_q != StAbsorb) || in_msg_q);

endmodule

// File: tb/tb_keymgr_kmac_rsp.sv
// Directed self-checking bench for keymgr_kmac_rsp (default build, stall feature off).
module tb_keymgr_kmac_rsp;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         req_valid_i;
   logic [63:0]  req_data_i;
   logic [7:0]   req_strb_i;
   logic         req_last_i;
   logic         req_ready_o;
   logic [255:0] mask_i;
   logic         rsp_done_o;
   logic [255:0] rsp_share0_o;
   logic [255:0] rsp_share1_o;
   logic         rsp_error_o;
   logic         busy_o;

   int errors = 0;
   int checks = 0;
   int lat, ready_hi, done_cnt;

   localparam logic [255:0] Mask5 = {64{4'h5}};

   keymgr_kmac_rsp dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_strb_i  (req_strb_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .mask_i      (mask_i),
      .rsp_done_o  (rsp_done_o),
      .rsp_share0_o(rsp_share0_o),
      .rsp_share1_o(rsp_share1_o),
      .rsp_error_o (rsp_error_o),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic to_next();
      @(posedge clk_i);
      #1;
   endtask

   // Entered at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
   task automatic send(input logic [63:0] d, input logic [7:0] s, input logic l);
      int n = 0;
      req_valid_i = 1'b1;
      req_data_i  = d;
      req_strb_i  = s;
      req_last_i  = l;
      #1;
      while (!req_ready_o && n < 50) begin
         @(posedge clk_i);
         #2;
         n++;
      end
      if (!req_ready_o) check("accept_timeout", 0, 1);
      to_next();
      req_valid_i = 1'b0;
      req_last_i  = 1'b0;
   endtask

   // Entered at posedge+2 of the first cycle after the last accept; ends in the done cycle.
   task automatic wait_done(output int l, output int rh);
      l  = 1;
      rh = 0;
      while (!rsp_done_o && l < 30) begin
         if (req_ready_o) rh++;
         @(posedge clk_i);
         #2;
         l++;
      end
   endtask

   initial begin
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      req_data_i  = '0;
      req_strb_i  = '0;
      req_last_i  = 1'b0;
      mask_i      = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready", req_ready_o, 0);
      check("rst_done", rsp_done_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_share0", rsp_share0_o, 0);
      rst_i = 1'b0;
      #1;
      check("ready_after_rst", req_ready_o, 1);
      to_next();

      // Test 1: single partial beat, zero mask
      send(64'h0123456789ABCDEF, 8'h0F, 1'b1);
      #1;
      check("t1_proc_ready", req_ready_o, 0);
      check("t1_proc_busy", busy_o, 1);
      check("t1_proc_share0", rsp_share0_o, 0);
      wait_done(lat, ready_hi);
      check("t1_latency", lat, 5);
      check("t1_share0", rsp_share0_o, 256'h89ABCDEF);
      check("t1_share1", rsp_share1_o, 0);
      check("t1_error", rsp_error_o, 0);
      check("t1_done_ready", req_ready_o, 0);
      to_next();
      check("t1_done_pulse", rsp_done_o, 0);
      check("t1_ready_back", req_ready_o, 1);
      check("t1_busy_idle", busy_o, 0);

      // Test 2: two full beats land in lanes 0 and 1
      send(64'd1, 8'hFF, 1'b0);
      #1;
      check("t2_busy_mid", busy_o, 1);
      send(64'd1, 8'hFF, 1'b1);
      #1;
      wait_done(lat, ready_hi);
      check("t2_latency", lat, 5);
      check("t2_share0", rsp_share0_o, 256'h1_0000000000000002);
      check("t2_error", rsp_error_o, 0);
      to_next();

      // Test 3: masked result; mask changes after sampling must not matter
      mask_i = Mask5;
      send(64'h0123456789ABCDEF, 8'h0F, 1'b1);
      mask_i = '0;
      #1;
      wait_done(lat, ready_hi);
      check("t3_share1", rsp_share1_o, Mask5);
      check("t3_xor", rsp_share0_o ^ rsp_share1_o, 256'h89ABCDEF);
      check("t3_error", rsp_error_o, 0);
      to_next();

      // Test 4: partial strobe on a non-last beat
      mask_i = Mask5;
      send(64'd1, 8'h7F, 1'b0);
      send(64'd2, 8'hFF, 1'b1);
      #1;
      wait_done(lat, ready_hi);
      check("t4_error", rsp_error_o, 1);
      check("t4_share0", rsp_share0_o, Mask5);
      check("t4_share1", rsp_share1_o, Mask5);
      to_next();

      // Last-beat strobe not of the form 2^n-1
      send(64'hFF, 8'h05, 1'b1);
      #1;
      wait_done(lat, ready_hi);
      check("t4b_error", rsp_error_o, 1);
      check("t4b_share0", rsp_share0_o, Mask5);
      to_next();

      // Legal contiguous last-beat strobe
      send(64'h0123456789ABCDEF, 8'h07, 1'b1);
      #1;
      wait_done(lat, ready_hi);
      check("t4c_error", rsp_error_o, 0);
      check("t4c_xor", rsp_share0_o ^ rsp_share1_o, 256'hABCDEF);
      to_next();

      // Exactly MaxBytes is legal
      mask_i = '0;
      for (int i = 0; i < 16; i++) send(64'd0, 8'hFF, i == 15);
      #1;
      wait_done(lat, ready_hi);
      check("t5a_error", rsp_error_o, 0);
      check("t5a_share0", rsp_share0_o, 0);
      to_next();

      // Test 5: 136 bytes overflows
      mask_i = Mask5;
      for (int i = 0; i < 17; i++) send(64'd0, 8'hFF, i == 16);
      #1;
      wait_done(lat, ready_hi);
      check("t5_latency", lat, 5);
      check("t5_ready_low", ready_hi, 0);
      check("t5_done_ready", req_ready_o, 0);
      check("t5_error", rsp_error_o, 1);
      check("t5_share0", rsp_share0_o, Mask5);
      to_next();
      check("t5_ready_after", req_ready_o, 1);

      // Test 6: reset mid-StProcess aborts the message
      mask_i = '0;
      send(64'h0123456789ABCDEF, 8'h0F, 1'b1);
      to_next();
      rst_i = 1'b1;
      #1;
      check("t6_rst_ready", req_ready_o, 0);
      check("t6_rst_busy", busy_o, 0);
      check("t6_rst_done", rsp_done_o, 0);
      to_next();
      rst_i = 1'b0;
      #1;
      check("t6_ready_release", req_ready_o, 1);
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_done_o) done_cnt++;
         to_next();
      end
      check("t6_no_done", done_cnt, 0);
      send(64'h0123456789ABCDEF, 8'h0F, 1'b1);
      #1;
      wait_done(lat, ready_hi);
      check("t6_latency", lat, 5);
      check("t6_share0", rsp_share0_o, 256'h89ABCDEF);
      check("t6_error", rsp_error_o, 0);
      to_next();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
